// File: rtl/aes_pkg.sv
// Shared AES helpers for the encrypt and decrypt cores.
// Contents:
//   aes_dec_state_t              decrypt-core FSM states
//   nk_of / nr_of                key size in bits -> Nk / Nr
//   xtime, gmul, ginv            GF(2^8) arithmetic, mod x^8+x^4+x^3+x+1
//   sbox, inv_sbox               computed from the field inverse and the affine map
//   sub_word, rot_word           key-schedule word operations
package aes_pkg;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} aes_dec_state_t;

  function automatic int nk_of(input int key_size);
    case (key_size)
      128:     return NK_128;
      192:     return NK_192;
      default: return NK_256;
    endcase
  endfunction

  function automatic int nr_of(input int key_size);
    return nk_of(key_size) + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0); 254 has every bit but bit 0 set
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] p;
    res = 8'h01;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) res = gmul(res, p);
      p = gmul(p, p);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int k);
    logic [15:0] d;
    d = {a, a} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse-round step.
// Ports:
//   state_in   [127:0]  current state, byte 0 = [127:120], column-major
//   round_key  [127:0]  round key for this step
//   first_flag          round Nr: AddRoundKey only
//   last_flag           round 0: no InvMixColumns
//   state_out  [127:0]  next state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         first_flag,
  input  logic         last_flag,
  output logic [127:0] state_out
);

  logic [127:0] isr;
  logic [127:0] ark;
  logic [127:0] imc;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // row r of output column c comes from input column (c - r) mod 4
  always_comb begin
    isr = '0;
    for (int k = 0; k < 16; k++) begin
      isr[127-8*k -: 8] = state_in[127-8*((((k/4) - (k%4) + 4) % 4)*4 + (k%4)) -: 8];
    end
  end

  always_comb begin
    ark = '0;
    for (int k = 0; k < 16; k++) begin
      ark[127-8*k -: 8] = inv_sbox(isr[127-8*k -: 8]) ^ round_key[127-8*k -: 8];
    end
  end

  always_comb begin
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
  end

  always_comb begin
    if (first_flag)     state_out = state_in ^ round_key;
    else if (last_flag) state_out = ark;
    else                state_out = imc;
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES inverse cipher: expands the key one word per cycle, then runs
// one inverse round per cycle from round Nr down to 0.
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iStart              start request, taken only while idle
//   iCiphertext [127:0] input block, byte 0 = [127:120]
//   iKey [KEY_SIZE-1:0] cipher key, word 0 in the top 32 bits
//   oPlaintext [127:0]  result, held from oDone until the next accepted start
//   oDone               one-cycle result strobe
//   oBusy               high while expanding or running rounds
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int KEY_SIZE = 192
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic [127:0]        iCiphertext,
  input  logic [KEY_SIZE-1:0] iKey,
  output logic [127:0]        oPlaintext,
  output logic                oDone,
  output logic                oBusy
);

  localparam int NK = nk_of(KEY_SIZE);
  localparam int NR = nr_of(KEY_SIZE);
  localparam int NW = 4 * (NR + 1);

  if (!(KEY_SIZE == 128 || KEY_SIZE == 192 || KEY_SIZE == 256)) begin : g_bad_key
    $error("aes_decrypt_core: KEY_SIZE must be 128, 192 or 256");
  end

  aes_dec_state_t state, state_nxt;

  logic [31:0]  w [NW];
  logic [127:0] s;
  logic [127:0] s_nxt;
  logic [127:0] rk;
  logic [5:0]   rbase;
  logic [3:0]   rnd;
  logic [5:0]   widx;
  logic [2:0]   kmod;   // widx mod NK, tracked incrementally to avoid a divider
  logic [7:0]   rcon;
  logic [31:0]  ktmp;
  logic [31:0]  knew;

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = KEXP;
      KEXP:    if (widx == 6'(NW-1)) state_nxt = ROUND;
      ROUND:   if (rnd == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // key-expansion word datapath
  always_comb begin
    ktmp = w[widx - 6'd1];
    if (kmod == 3'd0)                   ktmp = sub_word(rot_word(ktmp)) ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4)   ktmp = sub_word(ktmp);
    knew = w[widx - 6'(NK)] ^ ktmp;
  end

  always_comb begin
    rbase = {rnd, 2'b00};
    rk    = {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};
  end

  aes_inv_round u_round (
    .state_in   (s),
    .round_key  (rk),
    .first_flag (rnd == 4'(NR)),
    .last_flag  (rnd == 4'd0),
    .state_out  (s_nxt)
  );

  // control and outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oPlaintext <= '0;
      oDone      <= 1'b0;
      oBusy      <= 1'b0;
      rnd        <= '0;
      widx       <= '0;
      kmod       <= '0;
      rcon       <= 8'h01;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          oBusy <= 1'b1;
          widx  <= 6'(NK);
          kmod  <= '0;
          rcon  <= 8'h01;
        end
        KEXP: begin
          widx <= widx + 6'd1;
          kmod <= (kmod == 3'(NK-1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xtime(rcon);
          if (widx == 6'(NW-1)) rnd <= 4'(NR);
        end
        ROUND: begin
          if (rnd == 4'd0) begin
            oPlaintext <= s_nxt;
            oDone      <= 1'b1;
            oBusy      <= 1'b0;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // block state and round-key storage (not reset)
  always_ff @(posedge iClk) begin
    case (state)
      IDLE: if (iStart) begin
        s <= iCiphertext;
        for (int j = 0; j < NK; j++) w[j] <= iKey[KEY_SIZE-1-32*j -: 32];
      end
      KEXP:    w[widx] <= knew;
      ROUND:   s <= s_nxt;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: one instance per key size, FIPS-197 known
// answers, busy-start rejection, mid-round reset and encrypt/decrypt loopback.
module tb_aes_decrypt_core;
  import aes_pkg::*;

  typedef logic [127:0] blk_q_t[$];
  typedef int           cyc_q_t[$];

  typedef struct {
    int           inst;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst   [3];
  logic         start [3];
  logic [127:0] ct    [3];
  logic [127:0] pt    [3];
  logic         done  [3];
  logic         busy  [3];
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  blk_q_t exp_q [3];
  cyc_q_t acc_q [3];
  vec_t   kat   [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_decrypt_core #(.KEY_SIZE(128)) u_d128 (
    .iClk(clk), .iRst(rst[0]), .iStart(start[0]), .iCiphertext(ct[0]), .iKey(k128),
    .oPlaintext(pt[0]), .oDone(done[0]), .oBusy(busy[0]));
  aes_decrypt_core #(.KEY_SIZE(192)) u_d192 (
    .iClk(clk), .iRst(rst[1]), .iStart(start[1]), .iCiphertext(ct[1]), .iKey(k192),
    .oPlaintext(pt[1]), .oDone(done[1]), .oBusy(busy[1]));
  aes_decrypt_core #(.KEY_SIZE(256)) u_d256 (
    .iClk(clk), .iRst(rst[2]), .iStart(start[2]), .iCiphertext(ct[2]), .iKey(k256),
    .oPlaintext(pt[2]), .oDone(done[2]), .oBusy(busy[2]));

  function automatic int lat(input int i);
    return 51 + 8 * i;
  endfunction

  // ---------------- reference AES encryption ----------------
  function automatic logic [127:0] shift_rows(input logic [127:0] a);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = a[127-8*((((k/4) + (k%4)) % 4)*4 + (k%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] a);
    logic [127:0] o;
    logic [7:0]   b0, b1, b2, b3;
    for (int c = 0; c < 4; c++) begin
      {b0, b1, b2, b3} = a[127-32*c -: 32];
      o[127-32*c -: 32] = {gmul(b0,8'h02) ^ gmul(b1,8'h03) ^ b2 ^ b3,
                           b0 ^ gmul(b1,8'h02) ^ gmul(b2,8'h03) ^ b3,
                           b0 ^ b1 ^ gmul(b2,8'h02) ^ gmul(b3,8'h03),
                           gmul(b0,8'h03) ^ b1 ^ b2 ^ gmul(b3,8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [255:0] key, input int nk);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [127:0] s;
    logic [7:0]   rc;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[32*nk-1-32*j -: 32];
    for (int j = nk; j < 4*(nr+1); j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t  = sub_word(rot_word(t)) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk == 8 && j % 8 == 4) begin
        t = sub_word(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    s = p ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
      s = shift_rows(s);
      if (r < nr) s = mix_columns(s);
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic set_inputs(input int i, input logic [127:0] c, input logic [255:0] k);
    ct[i] = c;
    case (i)
      0:       k128 = k[127:0];
      1:       k192 = k[191:0];
      default: k256 = k;
    endcase
  endtask

  task automatic drive_start(input int i, input logic [127:0] c, input logic [255:0] k, input logic [127:0] p);
    set_inputs(i, c, k);
    start[i] = 1'b1;
    exp_q[i].push_back(p);
    acc_q[i].push_back(cyc + 1);
    @(posedge clk); #1;
    start[i] = 1'b0;
    set_inputs(i, ~c, ~k);   // inputs only matter in the accepting cycle
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (done[i] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL done_timeout inst%0d: no oDone within 200 cycles", i);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  task automatic check_blk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic check_idle(input int i, input string nm);
    check_blk($sformatf("%s_pt%0d", nm, i), pt[i], '0);
    check_bit($sformatf("%s_busy%0d", nm, i), busy[i], 1'b0);
    check_bit($sformatf("%s_done%0d", nm, i), done[i], 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic         pd [3];
    logic [127:0] e;
    int           a;
    for (int i = 0; i < 3; i++) pd[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done[i] === 1'b1) begin
          if (pd[i]) begin
            checks++; errors++;
            $display("FAIL done_twice inst%0d: oDone high two cycles in a row", i);
          end
          if (exp_q[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done inst%0d: pt=%h with nothing expected", i, pt[i]);
          end else begin
            e = exp_q[i].pop_front();
            a = acc_q[i].pop_front();
            check_blk($sformatf("plaintext_inst%0d", i), pt[i], e);
            checks++;
            if (cyc - a != lat(i)) begin
              errors++;
              $display("FAIL latency_inst%0d: got %0d cycles expected %0d", i, cyc - a, lat(i));
            end
          end
        end
        pd[i] = (done[i] === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] p, c;
    logic [255:0] k;
    int           nblk;

    kat[0] = '{0, 256'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT};
    kat[1] = '{1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
               128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT};
    kat[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h8ea2b7ca516745bfeafc49904b496089, PT};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; ct[i] = '0;
    end
    k128 = '0; k192 = '0; k256 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int i = 0; i < 3; i++) check_idle(i, "reset");

    // known-answer vectors
    for (int v = 0; v < 3; v++) begin
      drive_start(kat[v].inst, kat[v].ct, kat[v].key, kat[v].pt);
      check_bit($sformatf("busy_after_start%0d", v), busy[kat[v].inst], 1'b1);
      wait_done(kat[v].inst);
      @(posedge clk); #1;
      check_blk($sformatf("pt_held%0d", v), pt[kat[v].inst], kat[v].pt);
      check_bit($sformatf("busy_after_done%0d", v), busy[kat[v].inst], 1'b0);
    end

    // start pulse while busy is ignored
    drive_start(1, kat[1].ct, kat[1].key, PT);
    repeat (19) begin @(posedge clk); #1; end
    set_inputs(1, 128'hdeadbeef_0badf00d_12345678_9abcdef0, {8{32'hc3c3a5a5}});
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    wait_done(1);
    repeat (80) begin @(posedge clk); #1; end
    check_blk("pt_after_ignored_start", pt[1], PT);

    // reset during ROUND aborts the block
    drive_start(0, kat[0].ct, kat[0].key, PT);
    repeat (44) begin @(posedge clk); #1; end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    exp_q[0].delete();
    acc_q[0].delete();
    check_idle(0, "midreset");
    repeat (30) begin @(posedge clk); #1; end
    drive_start(0, kat[0].ct, kat[0].key, PT);
    wait_done(0);
    @(posedge clk); #1;

    // loopback, back-to-back starts in the oDone cycle
    for (int i = 0; i < 3; i++) begin
      nblk = (i == 0) ? 6 : 5;
      for (int n = 0; n < nblk; n++) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        c = aes_enc(p, k, 4 + 2*i);
        if (n > 0) wait_done(i);
        drive_start(i, c, k, p);
      end
      wait_done(i);
      @(posedge clk); #1;
    end

    repeat (5) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL missing_done inst%0d: %0d results outstanding, expected 0", i, exp_q[i].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
